// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Drives N_LED board LEDs with one of four patterns advanced by a
//   programmable prescaler tick: blink, chase, bounce, breathe.
//
//   Optional feature macro: LED_BREATHE_EN
//     defined   - breathe mode (duty counter + free-running PWM) is built.
//     undefined - duty/PWM logic is omitted and mode 3 is treated exactly
//                 as mode 0 (blink).
//
//   Ports
//     clk    in   1      system clock
//     rst    in   1      asynchronous active-high reset
//     en     in   1      1 = prescaler runs and pattern advances, 0 = freeze
//     mode   in   2      0 blink, 1 chase, 2 bounce, 3 breathe
//     led    out  N_LED  registered LED drive, 1 = lit
//     tick_o out  1      one-cycle pulse when a new step shows on led
module led_pattern_gen #(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 25000000,
    parameter int PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [N_LED-1:0] ONE_HOT0 = N_LED'(1);

    localparam logic [1:0] M_BLINK   = 2'd0;
    localparam logic [1:0] M_CHASE   = 2'd1;
    localparam logic [1:0] M_BOUNCE  = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    logic [CNT_W-1:0] cnt;
    logic             step;
    logic [1:0]       mode_smp;
    logic [1:0]       cur_mode,    cur_mode_nxt;
    logic [N_LED-1:0] pattern,     pattern_nxt;
    logic [N_LED-1:0] rot_left;
    logic             dir,         dir_nxt;     // 1 = left (bounce) / up (breathe)
    logic [N_LED-1:0] led_nxt;

`ifdef LED_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
`endif

    assign step = en && (cnt == CNT_MAX);

    // Without the breathe build, mode 3 is folded onto blink before the
    // change detector, so 0 <-> 3 switches are not seen as mode changes.
`ifdef LED_BREATHE_EN
    assign mode_smp = mode;
`else
    assign mode_smp = (mode == M_BREATHE) ? M_BLINK : mode;
`endif

    always_comb begin
        rot_left = '0;
        for (int i = 0; i < N_LED; i++) begin
            rot_left[(i + 1) % N_LED] = pattern[i];
        end
    end

    // Next-state: on a step either load the new mode's start state or
    // advance the current pattern engine by one position.
    always_comb begin
        cur_mode_nxt = cur_mode;
        pattern_nxt  = pattern;
        dir_nxt      = dir;
`ifdef LED_BREATHE_EN
        duty_nxt     = duty;
`endif
        if (step) begin
            if (mode_smp != cur_mode) begin
                cur_mode_nxt = mode_smp;
                case (mode_smp)
                    M_CHASE, M_BOUNCE: begin
                        pattern_nxt = ONE_HOT0;
                        dir_nxt     = 1'b1;
                    end
`ifdef LED_BREATHE_EN
                    M_BREATHE: begin
                        duty_nxt = '0;
                        dir_nxt  = 1'b1;
                    end
`endif
                    default: pattern_nxt = '0;
                endcase
            end else begin
                case (cur_mode)
                    M_CHASE: pattern_nxt = rot_left;
                    M_BOUNCE: begin
                        if (N_LED == 1) begin
                            pattern_nxt = ONE_HOT0;
                        end else if (dir) begin
                            if (pattern[N_LED-1]) begin
                                pattern_nxt = pattern >> 1;
                                dir_nxt     = 1'b0;
                            end else begin
                                pattern_nxt = pattern << 1;
                            end
                        end else begin
                            if (pattern[0]) begin
                                pattern_nxt = pattern << 1;
                                dir_nxt     = 1'b1;
                            end else begin
                                pattern_nxt = pattern >> 1;
                            end
                        end
                    end
`ifdef LED_BREATHE_EN
                    M_BREATHE: begin
                        if (dir) begin
                            if (duty == DUTY_MAX) begin
                                duty_nxt = DUTY_MAX - 1'b1;
                                dir_nxt  = 1'b0;
                            end else begin
                                duty_nxt = duty + 1'b1;
                            end
                        end else begin
                            if (duty == '0) begin
                                duty_nxt = PWM_BITS'(1);
                                dir_nxt  = 1'b1;
                            end else begin
                                duty_nxt = duty - 1'b1;
                            end
                        end
                    end
`endif
                    default: pattern_nxt = ~pattern;
                endcase
            end
        end
    end

    // Output: led is computed from the *next* mode/pattern/duty so a step
    // and any mode switch show on led at the same edge as tick_o rises.
    always_comb begin
        led_nxt = pattern_nxt;
`ifdef LED_BREATHE_EN
        if (cur_mode_nxt == M_BREATHE) begin
            led_nxt = {N_LED{pwm_cnt < duty_nxt}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tick_o   <= 1'b0;
            led      <= '0;
            pattern  <= '0;
            cur_mode <= M_BLINK;
            dir      <= 1'b1;
`ifdef LED_BREATHE_EN
            duty     <= '0;
            pwm_cnt  <= '0;
`endif
        end else begin
            if (en) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                led <= led_nxt;
            end
            tick_o   <= step;
            pattern  <= pattern_nxt;
            cur_mode <= cur_mode_nxt;
            dir      <= dir_nxt;
`ifdef LED_BREATHE_EN
            duty     <= duty_nxt;
            pwm_cnt  <= pwm_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the single-rate LED toggler: drives N_LED board LEDs from one on-board clock.
- A programmable prescaler generates a step tick; a small per-tick engine produces one of four selectable patterns: blink, chase, bounce, breathe.
- Sits directly behind board LED pins; mode/enable come from switches or a host register.

Parameters:
- N_LED, 8, number of LED outputs (>=1).
- TICK_DIV, 25000000, clk cycles per pattern step (>=2); prescaler width = $clog2(TICK_DIV).
- PWM_BITS, 8, breathe-mode duty/PWM resolution (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  1 = prescaler runs and pattern advances; 0 = freeze.
- mode  in  2  pattern select: 0 blink, 1 chase, 2 bounce, 3 breathe.
- led  out  N_LED  registered LED drive, 1 = lit.
- tick_o  out  1  one-cycle pulse, high in the cycle a new step becomes visible on led.

Behaviour:
- Reset (async assert, sync release): cnt=0, tick_o=0, led=0, pattern=0, cur_mode=0, dir=up/left, duty=0, pwm_cnt=0.
- Prescaler: when en=1, cnt increments each clk; at cnt==TICK_DIV-1 it wraps to 0 and a step occurs on that edge. When en=0, cnt, pattern, duty and led hold; tick_o=0.
- tick_o: registered; 1 for exactly the cycle after the wrap edge, i.e. period TICK_DIV clocks.
- mode is sampled only at a step edge. If sampled mode != cur_mode: cur_mode updates and the engine loads the new mode's start state instead of stepping.
- Start states: blink pattern=0; chase/bounce pattern=one-hot bit0, dir=left; breathe duty=0, dir=up.
- Blink step: pattern <= ~pattern (all bits together).
- Chase step: rotate left; bit N_LED-1 wraps to bit0.
- Bounce step: shift in dir. At bit N_LED-1 with dir=left, dir flips and the next value is bit N_LED-2. Symmetric behaviour at bit0. Never emits the same position twice in a row (N_LED>=2).
- N_LED==1: chase and bounce hold pattern=1.
- Breathe step: duty +/-1 per step. At 2^PWM_BITS-1 going up, flip to down and step to max-1. At 0 going down, flip to up and step to 1.
- pwm_cnt (PWM_BITS wide) free-runs every clk regardless of en.
- led in modes 0-2 = pattern. In mode 3, every led bit = registered (pwm_cnt < duty): duty 0 = always off; max duty = on 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- A mode change to or from breathe takes effect on led at the same step edge as the load.
- rst asserted mid-step: all state returns to reset values immediately; the first step after release occurs TICK_DIV clocks later.

Optional Feature:
- Macro LED_BREATHE_EN.
- Defined: breathe mode, duty counter and pwm_cnt are built as above.
- Undefined: duty/pwm logic is omitted; mode 3 behaves exactly as mode 0 (blink), including the start state on entry.

Test Plan (TICK_DIV=4, N_LED=4, PWM_BITS=2, macro defined unless stated):
- Blink: rst pulse, mode=0, en=1 -> led 0000 for 4 clks, then 1111, 0000, ... every 4 clks; tick_o high 1 cycle in 4, aligned with each change.
- Chase: mode=1 from reset -> first step loads 0001, then 0010, 0100, 1000, 0001.
- Bounce: mode=2 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Freeze/reset: chase at 0100, en=0 for 10 clks -> led holds 0100, tick_o=0. en=1 -> next value 1000. Assert rst mid-count -> led=0000 same cycle; first tick 4 clks after release.
- Breathe: mode=3 -> duty sequence 0,1,2,3,2,1,0,1. At duty=2 each 4-cycle PWM window shows led=1111 for exactly 2 cycles.
- Macro undefined, mode=3 -> identical waveform to the blink test.
